// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - types and alignment helper for the data-memory arbiter
`ifndef MASK_WIDTH
`include "defines.sv"
`endif

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_arb_state_e;

  typedef logic req_id_t;

  // True when the byte address is legal for the access size; unknown codes are illegal
  function automatic logic is_aligned(input logic [`MASK_WIDTH-1:0] mask,
                                      input logic [1:0]             addr_lo);
    logic ok;
    ok = 1'b0;
    case (mask)
      `MASK_W: ok = (addr_lo == 2'b00);
      `MASK_H: ok = !addr_lo[0];
      `MASK_B: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/defines.sv
// rtl/defines.sv - shared width and access-size macros for the data memory path
`ifndef DMEM_DEFINES_SV
`define DMEM_DEFINES_SV

`define MEM_ADDR_WIDTH 32
`define REG_DATA_WIDTH 32
`define MASK_WIDTH     2

// Access-size codes; 2'b11 is unused and treated as illegal
`define MASK_B 2'b00
`define MASK_H 2'b01
`define MASK_W 2'b10

`endif

// File: rtl/dmem_rr_arb2.sv
// rtl/dmem_rr_arb2.sv - two-way round-robin grant with last-grant history
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   valid[1:0]: pending requests
//   accept    : the current grant is being taken this cycle
//   grant     : winning requester (meaningful only when some valid is high)
module dmem_rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant
);

  // Resets to 1 so requester 0 wins the first conflict
  req_id_t last_grant;

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = !last_grant;
    end else begin
      grant = valid[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter and one-shot sequencer for the data memory
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   reqN_valid/ready/we/mask/addr/wdata : request channels, N = 0 (core) / 1 (debug/DMA)
//   rsp_valid/ready/id/rdata/err  : response channel, registered fields
//   mem_rd_en/wr_en/mask/addr/wr_data, mem_rd_data : memory port, driven only in ACCESS
`ifndef MASK_WIDTH
`include "defines.sv"
`endif

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = `MEM_ADDR_WIDTH,
  parameter int DATA_W = `REG_DATA_WIDTH,
  parameter int MASK_W = `MASK_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [MASK_W-1:0] req0_mask,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [MASK_W-1:0] req1_mask,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [MASK_W-1:0] mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  dmem_arb_state_e state, state_nxt;
  req_id_t         grant;
  logic            accept;

  logic              sel_we;
  logic [MASK_W-1:0] sel_mask;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ok;

  logic              cmd_we;
  logic [MASK_W-1:0] cmd_mask;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  dmem_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    sel_we    = req0_we;
    sel_mask  = req0_mask;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (grant) begin
      sel_we    = req1_we;
      sel_mask  = req1_mask;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
    sel_ok = is_aligned(sel_mask, sel_addr[1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is gated by valid so nothing reads as ready while idle with no traffic
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp_valid   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_mask    = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && (grant == 1'b0);
        req1_ready = req1_valid && (grant == 1'b1);
        accept     = req0_ready || req1_ready;
        if (accept) begin
          state_nxt = sel_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        mem_rd_en   = !cmd_we;
        mem_wr_en   = cmd_we;
        mem_mask    = cmd_mask;
        mem_addr    = cmd_addr;
        mem_wr_data = cmd_wdata;
        state_nxt   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response fields are only written on acceptance and in ACCESS, so they hold through RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we    <= 1'b0;
      cmd_mask  <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        cmd_we    <= sel_we;
        cmd_mask  <= sel_mask;
        cmd_addr  <= sel_addr;
        cmd_wdata <= sel_wdata;
        rsp_id    <= grant;
        rsp_err   <= !sel_ok;
        rsp_rdata <= '0;
      end
      if (state == ACCESS) begin
        rsp_rdata <= cmd_we ? '0 : mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
`ifndef MASK_WIDTH
`include "defines.sv"
`endif

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [1:0]  req0_mask;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [1:0]  req1_mask;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [1:0]  mem_mask;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] tb_mem  [0:255];
  logic [7:0] ref_mem [0:255];
  bit         mem_init = 1'b0;
  int         wr_cycles = 0;
  int         rd_cycles = 0;
  bit         tb_last;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_mask(req0_mask), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_mask(req1_mask), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory behind the DUT, little-endian, zero-extending reads
  logic [7:0] a0, a1, a2, a3;
  assign a0 = mem_addr[7:0];
  assign a1 = mem_addr[7:0] + 8'd1;
  assign a2 = mem_addr[7:0] + 8'd2;
  assign a3 = mem_addr[7:0] + 8'd3;
  assign mem_rd_data = (mem_mask == `MASK_B) ? {24'd0, tb_mem[a0]} :
                       (mem_mask == `MASK_H) ? {16'd0, tb_mem[a1], tb_mem[a0]} :
                       {tb_mem[a3], tb_mem[a2], tb_mem[a1], tb_mem[a0]};

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i * 37 + 5);
      mem_init <= 1'b1;
    end else if (mem_wr_en) begin
      tb_mem[a0] <= mem_wr_data[7:0];
      if (mem_mask != `MASK_B) tb_mem[a1] <= mem_wr_data[15:8];
      if (mem_mask == `MASK_W) begin
        tb_mem[a2] <= mem_wr_data[23:16];
        tb_mem[a3] <= mem_wr_data[31:24];
      end
    end
    if (mem_wr_en) wr_cycles <= wr_cycles + 1;
    if (mem_rd_en) rd_cycles <= rd_cycles + 1;
  end

  // ---------------- reference model ----------------
  function automatic bit ref_aligned(input logic [1:0] m, input logic [31:0] a);
    if (m == `MASK_B) return 1'b1;
    if (m == `MASK_H) return (a % 2) == 0;
    if (m == `MASK_W) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic int nbytes(input logic [1:0] m);
    return (m == `MASK_B) ? 1 : (m == `MASK_H) ? 2 : 4;
  endfunction

  task automatic model_access(input bit we, input logic [1:0] m, input logic [31:0] a,
                              input logic [31:0] d, output bit err, output logic [31:0] rd);
    logic [7:0] ix;
    err = !ref_aligned(m, a);
    rd  = '0;
    if (!err) begin
      for (int i = 0; i < nbytes(m); i++) begin
        ix = a[7:0] + 8'(i);
        if (we) ref_mem[ix] = d[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[ix];
      end
    end
  endtask

  function automatic logic ready_of(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input bit id, input bit v, input bit we, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] d);
    if (!id) begin
      req0_valid = v; req0_we = we; req0_mask = m; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_mask = m; req1_addr = a; req1_wdata = d;
    end
  endtask

  // One isolated transaction with rsp_ready high; checks latency, fields and memory enables
  task automatic single(input string nm, input bit id, input bit we, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] d,
                        output int waitc, output logic [31:0] rd);
    bit got, eerr;
    logic [31:0] erd;
    int lat, w0, r0;
    rd = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(id, 1'b1, we, m, a, d);
    waitc = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_of(id)) begin got = 1'b1; break; end
      waitc++;
    end
    n_cmp++;
    if (!got) begin
      n_fail++; $display("FAIL %s ready_timeout: ready=0 required=1", nm);
      set_req(id, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
      return;
    end
    w0 = wr_cycles; r0 = rd_cycles;
    @(posedge clk);
    tb_last = id;
    model_access(we, m, a, d, eerr, erd);
    #1 set_req(id, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); lat++;
      if (rsp_valid) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got || lat != (eerr ? 1 : 2)) begin
      n_fail++; $display("FAIL %s rsp_latency: got=%0d valid=%0b required=%0d", nm, lat, got, eerr ? 1 : 2);
    end
    rd = rsp_rdata;
    n_cmp++;
    if ({rsp_id, rsp_err, rsp_rdata} !== {id, eerr, erd}) begin
      n_fail++; $display("FAIL %s rsp_fields: id=%0b err=%0b rdata=%h required id=%0b err=%0b rdata=%h",
                         nm, rsp_id, rsp_err, rsp_rdata, id, eerr, erd);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ((wr_cycles - w0) != int'(we && !eerr) || (rd_cycles - r0) != int'(!we && !eerr) || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s mem_enables: wr=%0d rd=%0d rsp_valid=%0b required wr=%0d rd=%0d rsp_valid=0",
                         nm, wr_cycles - w0, rd_cycles - r0, rsp_valid, we && !eerr, !we && !eerr);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b0; rsp_ready = 1'b1;
    set_req(0, 0, 0, 2'b00, 0, 0);
    set_req(1, 0, 0, 2'b00, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
         mem_rd_en, mem_wr_en, mem_mask, mem_addr, mem_wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: rdy=%b%b rv=%b id=%b err=%b rd=%h ren=%b wen=%b mask=%b addr=%h wd=%h required all 0",
                         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
                         mem_rd_en, mem_wr_en, mem_mask, mem_addr, mem_wr_data);
    end
    @(posedge clk); #1 rst = 1'b1;
    tb_last = 1'b1;
  endtask

  task automatic test_store_load;
    int w; logic [31:0] rd;
    single("st_word", 0, 1, `MASK_W, 32'h10, 32'hDEADBEEF, w, rd);
    n_cmp++;
    if (w != 0) begin n_fail++; $display("FAIL st_first_ready: waited=%0d required=0", w); end
    single("ld_word", 0, 0, `MASK_W, 32'h10, 32'h0, w, rd);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_word_value: got=%h required=deadbeef", rd); end
  endtask

  task automatic test_halfword;
    int w; logic [31:0] rd;
    single("hw_st", 0, 1, `MASK_W, 32'h10, 32'h12345678, w, rd);
    single("hw_ld", 1, 0, `MASK_H, 32'h12, 32'h0, w, rd);
    n_cmp++;
    if (rd !== 32'h00001234) begin n_fail++; $display("FAIL hw_value: got=%h required=00001234", rd); end
    single("byte_ld", 1, 0, `MASK_B, 32'h13, 32'h0, w, rd);
    single("hw_bad", 0, 0, `MASK_H, 32'h13, 32'h0, w, rd);
  endtask

  task automatic test_misaligned;
    int w; logic [31:0] rd;
    single("misal_w", 0, 0, `MASK_W, 32'h11, 32'h0, w, rd);
    single("misal_st", 1, 1, `MASK_W, 32'h12, 32'hFFFFFFFF, w, rd);
    single("bad_code", 0, 0, 2'b11, 32'h10, 32'h0, w, rd);
  endtask

  task automatic test_back_to_back;
    bit got, gid, eerr;
    logic [31:0] erd;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    set_req(0, 1, 0, `MASK_W, 32'h10, 0);
    set_req(1, 1, 0, `MASK_W, 32'h14, 0);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got || (req0_ready && req1_ready)) begin
        n_fail++; $display("FAIL rr_ready_%0d: rdy=%b%b required exactly one", k, req1_ready, req0_ready);
      end
      gid = req1_ready;
      n_cmp++;
      if (gid !== !tb_last) begin n_fail++; $display("FAIL rr_order_%0d: granted=%0b required=%0b", k, gid, !tb_last); end
      @(posedge clk);
      tb_last = gid;
      model_access(1'b0, `MASK_W, gid ? 32'h14 : 32'h10, 32'h0, eerr, erd);
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1'b1; break; end
      end
      n_cmp++;
      if (!got || rsp_id !== gid || rsp_rdata !== erd) begin
        n_fail++; $display("FAIL rr_rsp_%0d: valid=%0b id=%0b rdata=%h required id=%0b rdata=%h", k, got, rsp_id, rsp_rdata, gid, erd);
      end
      @(posedge clk);
    end
    #1;
    set_req(0, 0, 0, 2'b00, 0, 0);
    set_req(1, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic test_stall;
    bit got, eerr;
    logic [31:0] erd;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, 1, 0, `MASK_W, 32'h10, 0);
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL stall_accept: ready=%b required=1", req0_ready); end
    @(posedge clk);
    tb_last = 1'b0;
    model_access(1'b0, `MASK_W, 32'h10, 32'h0, eerr, erd);
    #1;
    set_req(0, 0, 0, 2'b00, 0, 0);
    set_req(1, 1, 0, `MASK_W, 32'h14, 0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (!got || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_err !== eerr || rsp_rdata !== erd || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold_%0d: valid=%b id=%b err=%b rdata=%h rdy1=%b required valid=1 id=0 err=%b rdata=%h rdy1=0",
                           k, rsp_valid, rsp_id, rsp_err, rsp_rdata, req1_ready, eerr, erd);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n_cmp++;
    if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL stall_handshake_cycle: rdy1=%b required=0", req1_ready); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL stall_after: rdy1=%b required=1", req1_ready); end
    @(posedge clk);
    tb_last = 1'b1;
    model_access(1'b0, `MASK_W, 32'h14, 32'h0, eerr, erd);
    #1 set_req(1, 0, 0, 2'b00, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got || rsp_id !== 1'b1 || rsp_rdata !== erd) begin
      n_fail++; $display("FAIL stall_req1_rsp: valid=%b id=%b rdata=%h required id=1 rdata=%h", got, rsp_id, rsp_rdata, erd);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_access;
    int w; bit got, eerr; logic [31:0] rd, erd;
    single("pre20", 1, 1, `MASK_W, 32'h20, 32'hA5A5A5A5, w, rd);
    @(posedge clk); #1;
    set_req(0, 1, 1, `MASK_W, 32'h20, 32'h0BADF00D);
    @(negedge clk);
    @(posedge clk);
    #1 set_req(0, 0, 0, 2'b00, 0, 0);
    #1;
    n_cmp++;
    if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL rst_in_access: wr_en=%b required=1", mem_wr_en); end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
         mem_rd_en, mem_wr_en, mem_mask, mem_addr, mem_wr_data} !== '0) begin
      n_fail++; $display("FAIL rst_async_clear: rv=%b ren=%b wen=%b mask=%b addr=%h wd=%h required all 0",
                         rsp_valid, mem_rd_en, mem_wr_en, mem_mask, mem_addr, mem_wr_data);
    end
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if ({tb_mem[8'h23], tb_mem[8'h22], tb_mem[8'h21], tb_mem[8'h20]} !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL rst_no_commit: mem20=%h required=a5a5a5a5",
                         {tb_mem[8'h23], tb_mem[8'h22], tb_mem[8'h21], tb_mem[8'h20]});
    end
    @(negedge clk) rst = 1'b1;
    tb_last = 1'b1;
    @(posedge clk); #1;
    set_req(0, 1, 0, `MASK_W, 32'h20, 0);
    set_req(1, 1, 0, `MASK_W, 32'h24, 0);
    @(negedge clk);
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_first_grant: rdy1=%b rdy0=%b required rdy0 only", req1_ready, req0_ready);
    end
    @(posedge clk);
    tb_last = 1'b0;
    model_access(1'b0, `MASK_W, 32'h20, 32'h0, eerr, erd);
    #1;
    set_req(0, 0, 0, 2'b00, 0, 0);
    set_req(1, 0, 0, 2'b00, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got || rsp_rdata !== erd || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL rst_reload: valid=%b id=%b rdata=%h required id=0 rdata=%h", got, rsp_id, rsp_rdata, erd);
    end
    @(posedge clk);
  endtask

  // Random traffic on both ports checked cycle by cycle against the reference rules
  task automatic test_random;
    bit pend[2];
    bit p_we[2];
    logic [1:0]  p_m[2];
    logic [31:0] p_a[2], p_d[2];
    bit busy, exp_v, e_id, e_err, e_we, exp_r0, exp_r1, g;
    logic [31:0] e_rd;
    int bc, diff;
    busy = 0; bc = 0;
    for (int r = 0; r < 2; r++) begin pend[r] = 0; p_we[r] = 0; p_m[r] = 0; p_a[r] = 0; p_d[r] = 0; end
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      exp_v = 0; exp_r0 = 0; exp_r1 = 0;
      if (busy) begin
        bc++;
        exp_v = bc >= (e_err ? 1 : 2);
        n_cmp++;
        if (rsp_valid !== exp_v || {req0_ready, req1_ready} !== 2'b00 ||
            {mem_rd_en, mem_wr_en} !== {(bc == 1) && !e_err && !e_we, (bc == 1) && !e_err && e_we}) begin
          n_fail++; $display("FAIL rnd_busy_c%0d: rv=%b rdy=%b%b ren=%b wen=%b required rv=%b rdy=00 ren=%b wen=%b",
                             c, rsp_valid, req1_ready, req0_ready, mem_rd_en, mem_wr_en, exp_v,
                             (bc == 1) && !e_err && !e_we, (bc == 1) && !e_err && e_we);
        end
        if (exp_v) begin
          n_cmp++;
          if ({rsp_id, rsp_err, rsp_rdata} !== {e_id, e_err, e_rd}) begin
            n_fail++; $display("FAIL rnd_rsp_c%0d: id=%b err=%b rdata=%h required id=%b err=%b rdata=%h",
                               c, rsp_id, rsp_err, rsp_rdata, e_id, e_err, e_rd);
          end
        end
      end else begin
        exp_r0 = pend[0] && (!pend[1] || tb_last == 1'b1);
        exp_r1 = pend[1] && (!pend[0] || tb_last == 1'b0);
        n_cmp++;
        if ({req0_ready, req1_ready, rsp_valid} !== {exp_r0, exp_r1, 1'b0}) begin
          n_fail++; $display("FAIL rnd_idle_c%0d: rdy0=%b rdy1=%b rv=%b required rdy0=%b rdy1=%b rv=0",
                             c, req0_ready, req1_ready, rsp_valid, exp_r0, exp_r1);
        end
      end
      rsp_ready = (c >= 2950) || ($urandom_range(0, 3) != 0);
      if (!busy && (exp_r0 || exp_r1)) begin
        g = exp_r1;
        model_access(p_we[g], p_m[g], p_a[g], p_d[g], e_err, e_rd);
        e_id = g; e_we = p_we[g];
        busy = 1; bc = 0; tb_last = g; pend[g] = 0;
      end else if (busy && exp_v && rsp_ready) begin
        busy = 0;
      end
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && c < 2900 && $urandom_range(0, 1) == 1) begin
          pend[r] = 1;
          p_we[r] = 1'($urandom_range(0, 1));
          p_m[r]  = 2'($urandom_range(0, 3));
          p_a[r]  = 32'h40 + 32'($urandom_range(0, 31));
          p_d[r]  = $urandom;
        end
        set_req(r[0], pend[r], p_we[r], p_m[r], p_a[r], p_d[r]);
      end
    end
    diff = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) diff++;
    n_cmp++;
    if (diff != 0 || busy) begin
      n_fail++; $display("FAIL rnd_final_mem: differing_bytes=%0d busy=%b required 0 and 0", diff, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    test_reset();
    test_store_load();
    test_halfword();
    test_back_to_back();
    test_misaligned();
    test_stall();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish required finish");
    $fatal(1);
  end

endmodule
